// File: rtl/rob_superscalar.sv
// rob_superscalar: N-wide reorder buffer sitting between dispatch/rename and the RRAT.
// Up to DISP_W entries are allocated per cycle in program order. Entries are marked done
// through WB_PORTS completion ports. Up to CMT_W consecutive done entries retire per cycle,
// oldest first. A branch mispredict truncates every entry younger than the branch.
// Optional feature macro: ROB_WB_BYPASS_EN. When it is defined, a completion that arrives in
// the same cycle makes its entry eligible for commit in that cycle (0-cycle wb->commit).
// When it is undefined, commit sees only the registered done bits (1-cycle latency).
//
// Dispatch handshake: a slot k is taken in a cycle only when disp_valid[k], disp_ready and
// !flush_valid are all high at the rising edge. disp_ready depends only on the registered
// occupancy, so entries retired in the same cycle are not reused until the next cycle.
// If disp_valid is high while disp_ready is low, the slots are dropped, not held; the
// upstream stage must present them again. There is no back-pressure on commit or
// completion: cmt_valid slots retire unconditionally on the edge that follows.
module rob_superscalar #(
  parameter int DEPTH    = 32,
  parameter int DISP_W   = 2,
  parameter int CMT_W    = 2,
  parameter int WB_PORTS = 4,
  parameter int PREG_W   = 6,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DISP_W-1:0]             disp_valid,
  input  logic [DISP_W*PREG_W-1:0]      disp_pd,
  input  logic [DISP_W*5-1:0]           disp_rd,
  input  logic [DISP_W-1:0]             disp_is_br,
  output logic                          disp_ready,
  output logic [DISP_W*(IDX_W+1)-1:0]   disp_idx,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]     wb_idx,
  input  logic                          flush_valid,
  input  logic [IDX_W:0]                flush_idx,
  output logic [CMT_W-1:0]              cmt_valid,
  output logic [CMT_W*PREG_W-1:0]       cmt_pd,
  output logic [CMT_W*5-1:0]            cmt_rd,
  output logic [CMT_W-1:0]              cmt_is_br,
  output logic [IDX_W-1:0]              head_idx,
  output logic [IDX_W:0]                count
);

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] DISP_W_C = (PTR_W+1)'(DISP_W);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [PREG_W-1:0] pd_q [DEPTH];
  logic [4:0]        rd_q [DEPTH];
  logic [DEPTH-1:0]  br_q;

  logic [PTR_W-1:0]  count_w;
  logic [PTR_W:0]    free_w;
  logic              enq_en;
  logic [PTR_W-1:0]  n_enq;
  logic [PTR_W-1:0]  n_cmt;
  logic [IDX_W-1:0]  disp_eidx [DISP_W];
  logic [IDX_W-1:0]  cmt_eidx  [CMT_W];
  logic [CMT_W-1:0]  cmt_hit;
  logic [CMT_W-1:0]  cmt_ok;
  logic              cmt_chain;

  // Occupancy and free space come from registered pointers only.
  always_comb begin
    count_w    = tail_q - head_q;
    free_w     = DEPTH_C - {1'b0, count_w};
    disp_ready = (free_w >= DISP_W_C);
    enq_en     = disp_ready & ~flush_valid;
  end

  // Slot indices: dispatch slot k lands at tail+k, and commit slot j reads head+j.
  always_comb begin
    disp_idx = '0;
    for (int k = 0; k < DISP_W; k++) begin
      disp_idx[k*PTR_W +: PTR_W] = tail_q + PTR_W'(k);
      disp_eidx[k]               = tail_q[IDX_W-1:0] + IDX_W'(k);
    end
    for (int j = 0; j < CMT_W; j++) begin
      cmt_eidx[j] = head_q[IDX_W-1:0] + IDX_W'(j);
    end
  end

  // Number of entries allocated this cycle.
  always_comb begin
    n_enq = '0;
    for (int k = 0; k < DISP_W; k++) begin
      if (enq_en && disp_valid[k]) n_enq = n_enq + PTR_W'(1);
    end
  end

  // Per-window-slot completion status, optionally including same-cycle completions.
  always_comb begin
    cmt_hit = '0;
    for (int j = 0; j < CMT_W; j++) begin
      cmt_hit[j] = done_q[cmt_eidx[j]];
`ifdef ROB_WB_BYPASS_EN
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && (wb_idx[p*IDX_W +: IDX_W] == cmt_eidx[j])) cmt_hit[j] = 1'b1;
      end
`endif
    end
  end

  // Commit retires only an unbroken run of done entries that starts at head.
  always_comb begin
    cmt_ok    = '0;
    n_cmt     = '0;
    cmt_chain = 1'b1;
    for (int j = 0; j < CMT_W; j++) begin
      if (cmt_chain && (count_w > PTR_W'(j)) && cmt_hit[j]) begin
        cmt_ok[j] = 1'b1;
        n_cmt     = n_cmt + PTR_W'(1);
      end else begin
        cmt_chain = 1'b0;
      end
    end
  end

  // Commit payload outputs are read straight from the entry array at the head window.
  always_comb begin
    cmt_valid = cmt_ok;
    cmt_pd    = '0;
    cmt_rd    = '0;
    cmt_is_br = '0;
    for (int j = 0; j < CMT_W; j++) begin
      cmt_pd[j*PREG_W +: PREG_W] = pd_q[cmt_eidx[j]];
      cmt_rd[j*5 +: 5]           = rd_q[cmt_eidx[j]];
      cmt_is_br[j]               = br_q[cmt_eidx[j]];
    end
    head_idx = head_q[IDX_W-1:0];
    count    = count_w;
  end

  // Next pointers. A flush cuts tail back to just past the branch and drops any dispatch.
  always_comb begin
    head_d = head_q + n_cmt;
    if (flush_valid) tail_d = flush_idx + PTR_W'(1);
    else             tail_d = tail_q + n_enq;
  end

  // Next done bits. Priority from lowest to highest: writeback sets, then commit clears,
  // then allocation clears. So a bypass-committed entry does not keep its done bit, and
  // a newly allocated entry always starts not-done.
  always_comb begin
    done_d = done_q;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p]) done_d[wb_idx[p*IDX_W +: IDX_W]] = 1'b1;
    end
    for (int j = 0; j < CMT_W; j++) begin
      if (cmt_ok[j]) done_d[cmt_eidx[j]] = 1'b0;
    end
    for (int k = 0; k < DISP_W; k++) begin
      if (enq_en && disp_valid[k]) done_d[disp_eidx[k]] = 1'b0;
    end
  end

  // Pointer and completion state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      done_q <= done_d;
    end
  end

  // Entry payload. It needs no reset because an entry is only read after it is allocated.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DISP_W; k++) begin
      if (enq_en && disp_valid[k]) begin
        pd_q[disp_eidx[k]] <= disp_pd[k*PREG_W +: PREG_W];
        rd_q[disp_eidx[k]] <= disp_rd[k*5 +: 5];
        br_q[disp_eidx[k]] <= disp_is_br[k];
      end
    end
  end

endmodule

// File: tb/tb_rob_superscalar.sv
// tb_rob_superscalar: bench for rob_superscalar, built with DEPTH=8.
// The reference model is an in-order queue of pending entries with a done flag for each one.
// Directed scenarios pin the model with literal values. A randomized phase follows.
module tb_rob_superscalar;
  localparam int DEPTH    = 8;
  localparam int DISP_W   = 2;
  localparam int CMT_W    = 2;
  localparam int WB_PORTS = 4;
  localparam int PREG_W   = 6;
`ifdef ROB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  disp_valid;
  logic [11:0] disp_pd;
  logic [9:0]  disp_rd;
  logic [1:0]  disp_is_br;
  logic        disp_ready;
  logic [7:0]  disp_idx;
  logic [3:0]  wb_valid;
  logic [11:0] wb_idx;
  logic        flush_valid;
  logic [3:0]  flush_idx;
  logic [1:0]  cmt_valid;
  logic [11:0] cmt_pd;
  logic [9:0]  cmt_rd;
  logic [1:0]  cmt_is_br;
  logic [2:0]  head_idx;
  logic [3:0]  count;

  rob_superscalar #(
    .DEPTH(DEPTH), .DISP_W(DISP_W), .CMT_W(CMT_W), .WB_PORTS(WB_PORTS), .PREG_W(PREG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_pd(disp_pd), .disp_rd(disp_rd), .disp_is_br(disp_is_br),
    .disp_ready(disp_ready), .disp_idx(disp_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx),
    .flush_valid(flush_valid), .flush_idx(flush_idx),
    .cmt_valid(cmt_valid), .cmt_pd(cmt_pd), .cmt_rd(cmt_rd), .cmt_is_br(cmt_is_br),
    .head_idx(head_idx), .count(count)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard state: the pending entries {br,rd,pd}, oldest first, plus the absolute head pointer
  logic [11:0] exp_q[$];
  bit          done_m[$];
  int          m_head;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue position (0 = oldest) of an entry index
  function automatic int wb_pos(input logic [2:0] idx);
    return (int'(idx) - (m_head % DEPTH) + DEPTH) % DEPTH;
  endfunction

  // How many entries retire this cycle, given the model state and this cycle's completions
  function automatic int calc_ncmt(input logic [3:0] wbv, input logic [11:0] wbi);
    int n;
    bit hit;
    n = 0;
    for (int j = 0; j < CMT_W; j++) begin
      if (j >= exp_q.size()) break;
      hit = done_m[j];
      if (BYP) begin
        for (int p = 0; p < WB_PORTS; p++)
          if (wbv[p] && wb_pos(wbi[p*3 +: 3]) == j) hit = 1'b1;
      end
      if (!hit) break;
      n++;
    end
    return n;
  endfunction

  task automatic idle_inputs();
    disp_valid  = 2'b00;
    wb_valid    = 4'b0000;
    flush_valid = 1'b0;
  endtask

  // Driver: apply one cycle of inputs, check every output against the model, advance the model
  task automatic cycle(input logic [1:0] dv, input logic [11:0] dpd, input logic [9:0] drd,
                       input logic [1:0] dbr, input logic [3:0] wbv, input logic [11:0] wbi,
                       input logic fv, input logic [3:0] fidx);
    int sz, nc, tl, fp, keep, q;
    bit rdy;
    logic [1:0] ecv;
    logic [11:0] e;
    @(negedge clk);
    disp_valid = dv; disp_pd = dpd; disp_rd = drd; disp_is_br = dbr;
    wb_valid = wbv; wb_idx = wbi; flush_valid = fv; flush_idx = fidx;
    #1;
    sz  = exp_q.size();
    tl  = (m_head + sz) % 16;
    rdy = (DEPTH - sz) >= DISP_W;
    chk("count", 32'(count), 32'(sz));
    chk("disp_ready", 32'(disp_ready), 32'(rdy));
    chk("disp_idx", 32'(disp_idx), 32'({4'((tl + 1) % 16), 4'(tl)}));
    chk("head_idx", 32'(head_idx), 32'(m_head % DEPTH));
    nc  = calc_ncmt(wbv, wbi);
    ecv = (nc == 0) ? 2'b00 : (nc == 1) ? 2'b01 : 2'b11;
    chk("cmt_valid", 32'(cmt_valid), 32'(ecv));
    for (int j = 0; j < nc; j++) begin
      e = exp_q[j];
      chk("cmt_pd", 32'(cmt_pd[j*6 +: 6]), 32'(e[5:0]));
      chk("cmt_rd", 32'(cmt_rd[j*5 +: 5]), 32'(e[10:6]));
      chk("cmt_is_br", 32'(cmt_is_br[j]), 32'(e[11]));
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wbv[p]) begin
        q = wb_pos(wbi[p*3 +: 3]);
        if (q < sz) done_m[q] = 1'b1;
      end
    end
    fp = (int'(fidx) - m_head + 16) % 16;
    for (int j = 0; j < nc; j++) begin
      void'(exp_q.pop_front());
      void'(done_m.pop_front());
    end
    m_head = (m_head + nc) % 16;
    if (fv) begin
      keep = fp + 1 - nc;
      while (exp_q.size() > keep) begin
        void'(exp_q.pop_back());
        void'(done_m.pop_back());
      end
    end else if (rdy) begin
      for (int k = 0; k < DISP_W; k++) begin
        if (dv[k]) begin
          exp_q.push_back({dbr[k], drd[k*5 +: 5], dpd[k*6 +: 6]});
          done_m.push_back(1'b0);
        end
      end
    end
  endtask

  // Wait past the next edge and park the inputs so that literal checks see only the new state
  task automatic peek();
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
  endtask

  task automatic d2(input logic [5:0] p0, input logic [5:0] p1);
    cycle(2'b11, {p1, p0}, {p1[4:0] ^ 5'h1f, p0[4:0] ^ 5'h1f}, 2'b00, 4'b0, 12'b0, 1'b0, 4'b0);
  endtask

  task automatic wb(input logic [3:0] v, input logic [11:0] i);
    cycle(2'b00, 12'b0, 10'b0, 2'b00, v, i, 1'b0, 4'b0);
  endtask

  task automatic idle_cyc();
    cycle(2'b00, 12'b0, 10'b0, 2'b00, 4'b0, 12'b0, 1'b0, 4'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    exp_q.delete();
    done_m.delete();
    m_head = 0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_disp_idx", 32'(disp_idx), 32'h10);
    chk("rst_cmt_valid", 32'(cmt_valid), 32'd0);
    chk("rst_head_idx", 32'(head_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic random_phase(input int n);
    logic [1:0] dv;
    logic [11:0] dpd, wbi;
    logic [9:0] drd;
    logic [1:0] dbr;
    logic [3:0] wbv, fidx;
    logic fv;
    int sz, nc, lo, fp, q;
    for (int it = 0; it < n; it++) begin
      case ($urandom_range(0, 2))
        0:       dv = 2'b00;
        1:       dv = 2'b01;
        default: dv = 2'b11;
      endcase
      dpd = 12'($urandom);
      drd = 10'($urandom);
      dbr = 2'($urandom);
      wbv = '0;
      wbi = '0;
      sz  = exp_q.size();
      for (int p = 0; p < WB_PORTS; p++) begin
        if (sz > 0 && $urandom_range(0, 1) == 1) begin
          q = int'($urandom_range(0, sz - 1));
          if (!done_m[q]) begin
            wbv[p]       = 1'b1;
            wbi[p*3 +: 3] = 3'((m_head + q) % DEPTH);
          end
        end
      end
      fv   = 1'b0;
      fidx = '0;
      if (sz > 0 && $urandom_range(0, 15) == 0) begin
        nc   = calc_ncmt(wbv, wbi);
        lo   = (nc > 0) ? nc - 1 : 0;
        fp   = int'($urandom_range(lo, sz - 1));
        fv   = 1'b1;
        fidx = 4'((m_head + fp) % 16);
      end
      cycle(dv, dpd, drd, dbr, wbv, wbi, fv, fidx);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_head   = 0;
    rst = 1'b1;
    disp_valid = '0; disp_pd = '0; disp_rd = '0; disp_is_br = '0;
    wb_valid = '0; wb_idx = '0; flush_valid = 1'b0; flush_idx = '0;
    do_reset();

    // Reset in the middle of a run, with 5 entries occupied
    d2(6'd1, 6'd2);
    d2(6'd3, 6'd4);
    cycle(2'b01, 12'd5, 10'd5, 2'b00, 4'b0, 12'b0, 1'b0, 4'b0);
    peek();
    chk("t1_count_before", 32'(count), 32'd5);
    do_reset();

    // Fill to DEPTH, then present a fifth dispatch that must be ignored
    d2(6'd1, 6'd2);
    d2(6'd3, 6'd4);
    d2(6'd5, 6'd6);
    d2(6'd7, 6'd8);
    peek();
    chk("t2_count_full", 32'(count), 32'd8);
    chk("t2_ready_full", 32'(disp_ready), 32'd0);
    d2(6'd9, 6'd10);
    peek();
    chk("t2_count_ignored", 32'(count), 32'd8);
    chk("t2_disp_idx", 32'(disp_idx), 32'h98);
    do_reset();

    // Completions out of order and the in-order commit window
    d2(6'd10, 6'd11);
    d2(6'd12, 6'd13);
    wb(4'b0011, {3'd0, 3'd0, 3'd0, 3'd1});
    peek();
    chk("t3_cmt_valid", 32'(cmt_valid), BYP ? 32'd0 : 32'd3);
    chk("t3_cmt_pd", 32'(cmt_pd), BYP ? 32'({6'd13, 6'd12}) : 32'({6'd11, 6'd10}));
    wb(4'b0001, {3'd0, 3'd0, 3'd0, 3'd3});
    peek();
    chk("t3_blocked", 32'(cmt_valid), 32'd0);
    idle_cyc();
    wb(4'b0001, {3'd0, 3'd0, 3'd0, 3'd2});
    peek();
    chk("t3_unblocked", 32'(cmt_valid), BYP ? 32'd0 : 32'd3);
    idle_cyc();

    // Commit window that wraps from index 7 to index 0
    d2(6'd20, 6'd21);
    cycle(2'b11, {6'd23, 6'd22}, 10'h3ff, 2'b10, 4'b0011, {3'd0, 3'd0, 3'd5, 3'd4}, 1'b0, 4'b0);
    d2(6'd24, 6'd25);
    peek();
    chk("t4_count", 32'(count), 32'd4);
    chk("t4_head_idx", 32'(head_idx), 32'd6);
    wb(4'b0011, {3'd0, 3'd0, 3'd7, 3'd6});
    peek();
    chk("t4_cmt_valid", 32'(cmt_valid), BYP ? 32'd0 : 32'd3);
    idle_cyc();
    peek();
    chk("t4_head_wrapped", 32'(head_idx), 32'd0);
    chk("t4_count_after", 32'(count), 32'd2);

    // Flush at index 9 while tail is 12, with a dispatch in the same cycle
    d2(6'd30, 6'd31);
    cycle(2'b11, {6'd33, 6'd32}, 10'd0, 2'b00, 4'b0, 12'b0, 1'b1, 4'd9);
    peek();
    chk("t5_count", 32'(count), 32'd2);
    chk("t5_disp_idx", 32'(disp_idx), 32'hba);

    // Latency from completion to commit
    wb(4'b0001, {3'd0, 3'd0, 3'd0, 3'd0});
    chk("t6_same_cycle", 32'(cmt_valid[0]), 32'(BYP));
    peek();
    chk("t6_next_cycle", 32'(cmt_valid[0]), 32'(!BYP));
    idle_cyc();

    random_phase(3000);
    for (int i = 0; i < 8; i++) idle_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
